demux_14_tdm: RTL and testbench



---
 rtl/demux_14_tdm.sv | 149 ++++++++++++++
 tb/tb_demux_14_tdm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux_14_tdm.sv
// demux_14_tdm: rebuilds a 4-lane word from a Gray-ordered TDM slot stream.
// Optional macro DEMUX_PARITY_EN adds an even-parity fifth slot per frame.
module demux_14_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [4*WIDTH-1:0] o,
  output logic               o_valid,
  output logic [1:0]         s,
  output logic               err
);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         s_q, s_d;
  logic [4*WIDTH-1:0] sh_q, sh_d;
  logic [4*WIDTH-1:0] o_q, o_d;
  logic               ov_q, ov_d;
  logic               err_q, err_d;
  logic [4*WIDTH-1:0] merged;
  logic [1:0]         s_next;

`ifdef DEMUX_PARITY_EN
  logic               par_q, par_d;
`endif

  // Shadow word with the current slot dropped into lane index s.
  always_comb begin
    merged = sh_q;
    for (int k = 0; k < 4; k++) begin
      if (s_q == 2'(k)) merged[k*WIDTH +: WIDTH] = din;
    end
  end

  // Gray-order successor of the current select code.
  always_comb begin
    s_next = 2'b00;
    case (s_q)
      2'b00:   s_next = 2'b01;
      2'b01:   s_next = 2'b11;
      2'b11:   s_next = 2'b10;
      default: s_next = 2'b00;
    endcase
  end

  // Framing FSM: next-state, shadow and output strobes.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sh_d    = sh_q;
    o_d     = o_q;
    ov_d    = 1'b0;
    err_d   = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      HUNT: begin
        if (din_valid && sync) begin
          sh_d            = '0;
          sh_d[WIDTH-1:0] = din;
          s_d             = 2'b01;
          state_d         = COLLECT;
        end
      end
      default: begin
        if (din_valid) begin
          if (sync && s_q != 2'b00) begin
            err_d           = 1'b1;
            sh_d            = '0;
            sh_d[WIDTH-1:0] = din;
            s_d             = 2'b01;
`ifdef DEMUX_PARITY_EN
            par_d           = 1'b0;
`endif
          end else if (!sync && s_q == 2'b00) begin
            err_d   = 1'b1;
            state_d = HUNT;
`ifdef DEMUX_PARITY_EN
          end else if (par_q) begin
            par_d = 1'b0;
            s_d   = 2'b00;
            if (din[0] == ^sh_q) begin
              o_d  = sh_q;
              ov_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
`endif
          end else begin
            sh_d = merged;
            if (s_q == 2'b10) begin
`ifdef DEMUX_PARITY_EN
              par_d = 1'b1;
`else
              o_d  = merged;
              ov_d = 1'b1;
              s_d  = 2'b00;
`endif
            end else begin
              s_d = s_next;
            end
          end
        end
      end
    endcase
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      s_q     <= 2'b00;
      sh_q    <= '0;
      o_q     <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh_q    <= sh_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  // Parity-phase flag: set after slot 10, cleared by the parity slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  assign o       = o_q;
  assign o_valid = ov_q;
  assign s       = s_q;
  assign err     = err_q;

endmodule

// File: tb/tb_demux_14_tdm.sv
// tb_demux_14_tdm: scoreboard bench for demux_14_tdm (WIDTH=1).
// Stimulus pushes expected words; a negedge monitor pops on o_valid.
module tb_demux_14_tdm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] o;
  logic       o_valid;
  logic [1:0] s;
  logic       err;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [3:0] exp_q[$];

  demux_14_tdm #(.WIDTH(1)) dut (
    .clk(clk), .rst(rst), .din(din),
    .din_valid(din_valid), .sync(sync),
    .o(o), .o_valid(o_valid), .s(s), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every o_valid must match the next queued word.
  always @(negedge clk) begin
    if (err) err_seen++;
    if (o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL o_valid_unexpected actual=%b required=none", o);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL o_word actual=%b required=%b", o, e);
        end
      end
    end
  end

  task automatic slot(input logic d, input logic sy);
    din = d; din_valid = 1'b1; sync = sy;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0; din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Slot order follows Gray select: lanes 0,1,3,2.
  task automatic frame(input logic [3:0] w, input logic good_par);
    slot(w[0], 1'b1);
    slot(w[1], 1'b0);
    slot(w[3], 1'b0);
    slot(w[2], 1'b0);
`ifdef DEMUX_PARITY_EN
    slot(good_par ? ^w : ~^w, 1'b0);
`endif
  endtask

  initial begin
    #2;
    check("rst_o", int'(o), 0);
    check("rst_ov", int'(o_valid), 0);
    check("rst_s", int'(s), 0);
    check("rst_err", int'(err), 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // Basic frame 1010.
    exp_q.push_back(4'b1010);
    frame(4'b1010, 1'b1);
    idle(1);
    check("f1_s", int'(s), 0);
    check("f1_err", err_seen, err_exp);

    // Back-to-back 1010 with a gap, then 0101.
    exp_q.push_back(4'b1010);
    slot(1'b0, 1'b1);
    slot(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("gap_s", int'(s), 3);
    end
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
`ifdef DEMUX_PARITY_EN
    slot(1'b0, 1'b0);
`endif
    exp_q.push_back(4'b0101);
    frame(4'b0101, 1'b1);
    idle(1);
    check("b2b_o", int'(o), 5);
    check("b2b_err", err_seen, err_exp);

    // Sync at s==11 aborts 1010; restart carries 0110.
    slot(1'b0, 1'b1);
    slot(1'b1, 1'b0);
    check("abort_pre_s", int'(s), 3);
    err_exp++;
    exp_q.push_back(4'b0110);
    slot(1'b0, 1'b1);
    check("abort_s", int'(s), 1);
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
    slot(1'b1, 1'b0);
`ifdef DEMUX_PARITY_EN
    slot(1'b0, 1'b0);
`endif
    idle(1);
    check("abort_o", int'(o), 6);
    check("abort_err", err_seen, err_exp);

    // Good 1010, then slot 0 without sync drops to HUNT.
    exp_q.push_back(4'b1010);
    frame(4'b1010, 1'b1);
    err_exp++;
    slot(1'b1, 1'b0);
    idle(1);
    check("nosync_err", err_seen, err_exp);
    check("nosync_o", int'(o), 10);
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
    slot(1'b1, 1'b0);
    check("hunt_s", int'(s), 0);
    check("hunt_err", err_seen, err_exp);

    // Reset at s==11 clears everything asynchronously.
    slot(1'b1, 1'b1);
    slot(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_o", int'(o), 0);
    check("arst_s", int'(s), 0);
    check("arst_ov", int'(o_valid), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(4'b1111);
    frame(4'b1111, 1'b1);
    idle(1);
    check("post_rst_o", int'(o), 15);

`ifdef DEMUX_PARITY_EN
    exp_q.push_back(4'b1010);
    frame(4'b1010, 1'b1);
    err_exp++;
    slot(1'b1, 1'b1);
    slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
    slot(1'b0, 1'b0);
    idle(1);
    check("par_bad_o", int'(o), 10);
`endif

    idle(2);
    check("err_total", err_seen, err_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
